// File: rtl/barcode_rx.sv
// Barcode receiver: measures the start-bit low time as a half period, then samples each bit half a period after its falling edge.
// ID/ID_vld update 2 cycles after the last sample; never stalls, a held ID_vld is overwritten by the next valid frame.
module barcode_rx #(
   parameter int ID_W     = 8,
   parameter int CHK_W    = 2,
   parameter int CNT_W    = 22,
   parameter int TMO_MULT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            BC,
   input  logic            clr_ID_vld,
   output logic [ID_W-1:0] ID,
   output logic            ID_vld,
   output logic            err,
   output logic            busy
);

   localparam int BW = $clog2(ID_W + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [BW-1:0]    BIT_ONE  = 1;
   localparam logic [BW-1:0]    BIT_LAST = BW'(ID_W - 1);
   localparam logic [CNT_W+2:0] MULT     = (CNT_W+3)'(TMO_MULT);

   typedef enum logic [2:0] {IDLE, START, WAIT, SAMPLE, CHECK} state_t;

   state_t            state, state_nxt;
   logic              bc_m, bc_s, bc_q, fe;
   logic [CNT_W-1:0]  half_cnt, half_nxt;
   logic [CNT_W-1:0]  tmo_cnt, tmo_nxt;
   logic [BW-1:0]     bit_cnt, bit_nxt;
   logic [ID_W-1:0]   sr, sr_nxt;
   logic [CNT_W+2:0]  tmo_lim;
   logic              chk_ok, id_load, err_set;

   // bc_q only remembers the previous synced value for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bc_m <= 1'b1;
         bc_s <= 1'b1;
         bc_q <= 1'b1;
      end else begin
         bc_m <= BC;
         bc_s <= bc_m;
         bc_q <= bc_s;
      end
   end

   assign fe      = bc_q & ~bc_s;
   assign tmo_lim = MULT * {3'b000, half_cnt};
   assign busy    = (state != IDLE);

   generate
      if (CHK_W == 0) begin : g_nochk
         assign chk_ok = 1'b1;
      end else begin : g_chk
         assign chk_ok = ~|sr[ID_W-1 -: CHK_W];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         half_cnt <= '0;
         tmo_cnt  <= '0;
         bit_cnt  <= '0;
         sr       <= '0;
         ID       <= '0;
         ID_vld   <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         half_cnt <= half_nxt;
         tmo_cnt  <= tmo_nxt;
         bit_cnt  <= bit_nxt;
         sr       <= sr_nxt;
         err      <= err_set;
         if (id_load) begin
            ID <= sr;
         end
         ID_vld   <= id_load | (ID_vld & ~clr_ID_vld);
      end
   end

   always_comb begin
      state_nxt = state;
      half_nxt  = half_cnt;
      tmo_nxt   = tmo_cnt;
      bit_nxt   = bit_cnt;
      sr_nxt    = sr;
      id_load   = 1'b0;
      err_set   = 1'b0;
      case (state)
         IDLE: begin
            if (fe) begin
               half_nxt  = '0;
               bit_nxt   = '0;
               state_nxt = START;
            end
         end
         START: begin
            if (bc_s) begin
               tmo_nxt   = '0;
               state_nxt = WAIT;
            end else if (half_cnt == CNT_MAX) begin
               err_set   = 1'b1;
               state_nxt = IDLE;
            end else begin
               half_nxt  = half_cnt + CNT_ONE;
            end
         end
         WAIT: begin
            // a wrapping tmo_cnt would never reach a limit above CNT_MAX, so saturation aborts too
            if (fe) begin
               tmo_nxt   = '0;
               state_nxt = SAMPLE;
            end else if (({3'b000, tmo_cnt} >= tmo_lim) || (tmo_cnt == CNT_MAX)) begin
               err_set   = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmo_nxt   = tmo_cnt + CNT_ONE;
            end
         end
         SAMPLE: begin
            if (tmo_cnt == half_cnt) begin
               sr_nxt    = {sr[ID_W-2:0], bc_s};
               bit_nxt   = bit_cnt + BIT_ONE;
               tmo_nxt   = '0;
               state_nxt = (bit_cnt == BIT_LAST) ? CHECK : WAIT;
            end else begin
               tmo_nxt   = tmo_cnt + CNT_ONE;
            end
         end
         CHECK: begin
            state_nxt = IDLE;
            if (chk_ok) begin
               id_load = 1'b1;
            end else begin
               err_set = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_barcode_rx.sv
// Bench for barcode_rx: an 8-bit/2-check-bit instance and a 12-bit/no-check instance on one clock.
// Expected outputs come from a per-cycle event schedule derived from the frames being driven.
module tb_barcode_rx;

   localparam int MAXC = 20000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bc0, bc1, clr0, clr1;
   logic [7:0]  id0;
   logic [11:0] id1;
   logic        vld0, vld1, err0, err1, busy0, busy1;

   always #5 clk = ~clk;

   barcode_rx #(.ID_W(8), .CHK_W(2), .CNT_W(22), .TMO_MULT(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .BC(bc0), .clr_ID_vld(clr0),
      .ID(id0), .ID_vld(vld0), .err(err0), .busy(busy0)
   );

   barcode_rx #(.ID_W(12), .CHK_W(0), .CNT_W(22), .TMO_MULT(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .BC(bc1), .clr_ID_vld(clr1),
      .ID(id1), .ID_vld(vld1), .err(err1), .busy(busy1)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // expected-event schedule, indexed [instance][cycle]
   bit          on_at  [2][MAXC];
   bit          off_at [2][MAXC];
   bit          err_at [2][MAXC];
   bit          set_at [2][MAXC];
   logic [15:0] set_val[2][MAXC];

   int n_chk  = 0;
   int n_fail = 0;
   int errcnt[2];
   int rise_cyc[2];
   int err_cyc[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // compare process: model state advanced from the schedule, checked every cycle
   logic        m_busy[2], m_vld[2], prev_clr[2], prev_vld[2];
   logic [15:0] m_id[2];
   logic        a_busy, a_vld, a_err;
   logic [15:0] a_id;

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 1'b0; m_vld[i] = 1'b0; m_id[i] = '0;
         prev_clr[i] = 1'b0; prev_vld[i] = 1'b0;
         errcnt[i] = 0; rise_cyc[i] = -1; err_cyc[i] = -1;
      end
      forever begin
         @(negedge clk);
         if (cyc < MAXC) begin
            for (int i = 0; i < 2; i++) begin
               if (!rst_n) begin
                  m_busy[i] = 1'b0; m_vld[i] = 1'b0; m_id[i] = '0;
               end else begin
                  if (on_at[i][cyc])  m_busy[i] = 1'b1;
                  if (off_at[i][cyc]) m_busy[i] = 1'b0;
                  if (set_at[i][cyc]) begin
                     m_vld[i] = 1'b1;
                     m_id[i]  = set_val[i][cyc];
                  end else if (prev_clr[i]) begin
                     m_vld[i] = 1'b0;
                  end
               end
               a_busy = (i == 0) ? busy0 : busy1;
               a_vld  = (i == 0) ? vld0  : vld1;
               a_err  = (i == 0) ? err0  : err1;
               a_id   = (i == 0) ? {8'h00, id0} : {4'h0, id1};
               check((i == 0) ? "dut0 busy"   : "dut1 busy",   32'(a_busy), 32'(m_busy[i]));
               check((i == 0) ? "dut0 ID_vld" : "dut1 ID_vld", 32'(a_vld),  32'(m_vld[i]));
               check((i == 0) ? "dut0 ID"     : "dut1 ID",     32'(a_id),   32'(m_id[i]));
               check((i == 0) ? "dut0 err"    : "dut1 err",    32'(a_err),  32'(rst_n && err_at[i][cyc]));
               if (a_err) begin
                  errcnt[i]++;
                  err_cyc[i] = cyc;
               end
               if (a_vld && !prev_vld[i]) rise_cyc[i] = cyc;
               prev_vld[i] = a_vld;
               prev_clr[i] = (i == 0) ? clr0 : clr1;
            end
         end
      end
   end

   initial begin
      #(MAXC * 10);
      $display("FAIL watchdog: cycle budget of %0d exhausted", MAXC);
      $fatal(1);
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int inst, input logic v);
      if (inst == 0) bc0 = v; else bc1 = v;
   endtask

   task automatic drive_clr(input int inst, input logic v);
      if (inst == 0) clr0 = v; else clr1 = v;
   endtask

   // Start bit low n cycles then high n (bit period 2n); '1' is low a quarter period, '0' three quarters.
   // The cycle the falling edge is seen counts as IDLE, so the measured half period is n-1.
   // Edge in cycle f reaches bc_s in f+2, sample taken in f+3+half, CHECK in f+4+half, outputs in f+5+half.
   task automatic send_bits(input int inst, input logic [15:0] val, input int nbits, input int nsend,
                            input int n, input bit clr_chk, output int last_f);
      int half, period, low, f, chk_c, clr_c;
      bit ok, b;
      half   = n - 1;
      period = 2 * n;
      on_at[inst][cyc + 3] = 1'b1;
      drive(inst, 1'b0);
      wait_cyc(n);
      drive(inst, 1'b1);
      wait_cyc(n);
      last_f = cyc;
      for (int k = 0; k < nsend; k++) begin
         f      = cyc;
         last_f = f;
         b      = val[nbits-1-k];
         clr_c  = -1;
         if (k == nbits - 1) begin
            chk_c = f + 4 + half;
            ok    = (inst == 1) || (val[7:6] == 2'b00);
            off_at[inst][chk_c + 1] = 1'b1;
            if (ok) begin
               set_at[inst][chk_c + 1]  = 1'b1;
               set_val[inst][chk_c + 1] = val;
            end else begin
               err_at[inst][chk_c + 1] = 1'b1;
            end
            if (clr_chk) clr_c = chk_c;
         end
         low = b ? period / 4 : (3 * period) / 4;
         for (int j = 0; j < period; j++) begin
            drive(inst, logic'(j >= low));
            drive_clr(inst, logic'(cyc == clr_c));
            wait_cyc(1);
         end
      end
      drive_clr(inst, 1'b0);
   endtask

   initial begin
      int lf, e0;
      rst_n = 1'b0; bc0 = 1'b1; bc1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ID", 32'(id0), 32'h0);
      check("reset ID_vld", 32'(vld0), 32'h0);
      check("reset busy", 32'(busy0), 32'h0);
      check("reset err", 32'(err0), 32'h0);
      rst_n = 1'b1;
      wait_cyc(5);
      check("idle busy", 32'(busy0), 32'h0);

      // 0x2A, half period 100
      send_bits(0, 16'h2A, 8, 8, 100, 1'b0, lf);
      wait_cyc(20);
      check("2A ID", 32'(id0), 32'h2A);
      check("2A ID_vld", 32'(vld0), 32'h1);
      check("2A latency", 32'(rise_cyc[0] - lf), 32'd104);
      check("2A no err", 32'(errcnt[0]), 32'd0);

      // 0xC5 fails the check bits
      e0 = errcnt[0];
      send_bits(0, 16'hC5, 8, 8, 100, 1'b0, lf);
      wait_cyc(20);
      check("C5 ID kept", 32'(id0), 32'h2A);
      check("C5 ID_vld kept", 32'(vld0), 32'h1);
      check("C5 one err", 32'(errcnt[0] - e0), 32'd1);

      // acknowledge, then a redundant acknowledge
      drive_clr(0, 1'b1); wait_cyc(1); drive_clr(0, 1'b0); wait_cyc(1);
      check("clr ID_vld", 32'(vld0), 32'h0);
      drive_clr(0, 1'b1); wait_cyc(1); drive_clr(0, 1'b0); wait_cyc(1);
      check("clr idle ID_vld", 32'(vld0), 32'h0);
      check("clr ID kept", 32'(id0), 32'h2A);

      // back-to-back frames without ack; ack collides with the second CHECK
      send_bits(0, 16'h11, 8, 8, 100, 1'b0, lf);
      wait_cyc(20);
      check("11 ID", 32'(id0), 32'h11);
      send_bits(0, 16'h22, 8, 8, 100, 1'b1, lf);
      wait_cyc(20);
      check("22 ID", 32'(id0), 32'h22);
      check("22 set wins", 32'(vld0), 32'h1);

      // timeout: half 49, limit 196; WAIT entered f+53, abort seen at f+53+196+1
      e0 = errcnt[0];
      send_bits(0, 16'hA0, 8, 3, 50, 1'b0, lf);
      off_at[0][lf + 250] = 1'b1;
      err_at[0][lf + 250] = 1'b1;
      wait_cyc(300);
      check("tmo one err", 32'(errcnt[0] - e0), 32'd1);
      check("tmo err cycle", 32'(err_cyc[0] - lf), 32'd250);
      check("tmo busy", 32'(busy0), 32'h0);
      check("tmo ID kept", 32'(id0), 32'h22);

      // reset during the high part of bit 5
      e0 = errcnt[0];
      send_bits(0, 16'h3F, 8, 5, 100, 1'b0, lf);
      drive(0, 1'b0); wait_cyc(50);
      drive(0, 1'b1); wait_cyc(70);
      rst_n = 1'b0; wait_cyc(1);
      rst_n = 1'b1; wait_cyc(200);
      check("rst busy", 32'(busy0), 32'h0);
      check("rst ID_vld", 32'(vld0), 32'h0);
      check("rst ID", 32'(id0), 32'h0);
      send_bits(0, 16'h3F, 8, 8, 100, 1'b0, lf);
      wait_cyc(20);
      check("3F ID", 32'(id0), 32'h3F);
      check("3F ID_vld", 32'(vld0), 32'h1);
      check("3F no err", 32'(errcnt[0] - e0), 32'd0);

      // 12-bit instance, no check bits
      send_bits(1, 16'hFFF, 12, 12, 100, 1'b0, lf);
      wait_cyc(20);
      check("FFF ID", 32'(id1), 32'hFFF);
      check("FFF ID_vld", 32'(vld1), 32'h1);
      check("FFF no err", 32'(errcnt[1]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
